// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM states, default geometry
// and helpers used by the RTL and by benches that pre-fill program memory.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } loader_state_t;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_ADDR_W  = 8;
    localparam int PROG_DEPTH  = 1 << DEF_ADDR_W;
    localparam int INSTR_BYTES = DEF_INSTR_W / 8;

    // jal x0, 0 : a self-loop, so a cpu fetching unloaded memory just spins
    localparam logic [DEF_INSTR_W-1:0] STALL_INSTRUCTION = 32'h0000_006F;

    // A count byte of zero encodes a full memory of 2**addr_w words.
    function automatic int unsigned word_count(input logic [7:0] count_byte,
                                               input int unsigned addr_w);
        if (count_byte == 8'd0) begin
            return 32'd1 << addr_w;
        end
        return {24'd0, count_byte};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Bundle of the loader's byte-stream input, program-memory write port,
// control/status levels and the loader FSM state for observation.
interface prog_loader_if
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) ();

    // Byte stream handshake: a byte transfers on a rising clk edge where
    // in_valid && in_ready are both high; in_valid may rise regardless of
    // in_ready, in_data only matters while in_valid is high, and a byte
    // offered while in_ready is low is simply left pending.
    logic                start;
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;

    logic [ADDR_W-1:0]   prog_address;
    logic [INSTR_W-1:0]  prog_wdata;
    logic                prog_write_enable;

    logic                cpu_hold;
    logic                done;
    logic                error;
    loader_state_t       state;

    modport master (
        input  start, in_valid, in_data,
        output in_ready, prog_address, prog_wdata, prog_write_enable,
        output cpu_hold, done, error, state
    );

    modport slave (
        output start, in_valid, in_data,
        input  in_ready, prog_address, prog_wdata, prog_write_enable,
        input  cpu_hold, done, error, state
    );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// MSB-first byte packer: collects INSTR_W/8 bytes and presents the finished
// word with a one-cycle word_valid pulse on the cycle after the last byte.
module prog_loader_byte_packer #(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [7:0]         byte_in,
    output logic               last_byte,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    localparam int BYTES = INSTR_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0]   byte_cnt;
    logic [INSTR_W-1:0] shreg;
    logic [INSTR_W-1:0] shifted;

    generate
        if (BYTES > 1) begin : g_multi
            assign shifted = {shreg[INSTR_W-9:0], byte_in};
        end else begin : g_single
            assign shifted = byte_in;
        end
    endgenerate

    assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));

    // word holds the last completed word so the write data stays stable
    // while the next word is being shifted in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt   <= '0;
            shreg      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                byte_cnt <= '0;
                shreg    <= '0;
            end else if (enable) begin
                shreg <= shifted;
                if (last_byte) begin
                    byte_cnt   <= '0;
                    word       <= shifted;
                    word_valid <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Program loader: count byte + MSB-first instruction bytes -> program memory
// writes, holding the cpu in reset until a good load. Option: PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                INSTR_W   = DEF_INSTR_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst,
    prog_loader_if.master  bus
);

    loader_state_t      state;
    loader_state_t      state_next;
    logic               ready;
    logic               accept;
    logic               pack_en;
    logic               pack_clear;
    logic               last_byte;
    logic               word_valid;
    logic [INSTR_W-1:0] word;
    logic [ADDR_W:0]    words_left;
    logic [ADDR_W-1:0]  addr;
    logic               load_start;

    assign accept     = bus.in_valid && ready;
    assign pack_en    = (state == DATA) && accept;
    assign pack_clear = (state == COUNT);
    assign load_start = ((state == IDLE) || (state == DONE)) && bus.start;

    prog_loader_byte_packer #(.INSTR_W(INSTR_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (pack_clear),
        .enable     (pack_en),
        .byte_in    (bus.in_data),
        .last_byte  (last_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DATA stays put through the final write strobe with in_ready low, so
    // done only rises the cycle after the last word has been written.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_next = COUNT;
            end
            COUNT: begin
                ready = 1'b1;
                if (bus.in_valid) state_next = DATA;
            end
            DATA: begin
                ready = (words_left != '0);
                if ((words_left == '0) && word_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK: begin
                ready = 1'b1;
                if (bus.in_valid) state_next = DONE;
            end
`endif
            DONE: begin
                if (bus.start) state_next = COUNT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_left <= '0;
            addr       <= BASE_ADDR;
        end else begin
            if ((state == COUNT) && accept) begin
                words_left <= (ADDR_W+1)'(word_count(bus.in_data, ADDR_W));
                addr       <= BASE_ADDR;
            end else begin
                if (pack_en && last_byte) begin
                    words_left <= words_left - (ADDR_W+1)'(1);
                end
                if (word_valid) begin
                    addr <= addr + ADDR_W'(1);
                end
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    logic       err;

    // Running XOR over data bytes only; the count byte resets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
            err  <= 1'b0;
        end else begin
            if (load_start) begin
                err <= 1'b0;
            end
            if ((state == COUNT) && accept) begin
                csum <= '0;
            end else if (pack_en) begin
                csum <= csum ^ bus.in_data;
            end
            if ((state == CHECK) && accept) begin
                err <= (bus.in_data != csum);
            end
        end
    end

    assign bus.error    = err;
    assign bus.cpu_hold = !((state == DONE) && !err);
`else
    logic unused_start;
    assign unused_start = load_start;
    assign bus.error    = 1'b0;
    assign bus.cpu_hold = (state != DONE);
`endif

    assign bus.in_ready          = ready;
    assign bus.prog_address      = addr;
    assign bus.prog_wdata        = word;
    assign bus.prog_write_enable = word_valid;
    assign bus.done              = (state == DONE);
    assign bus.state             = state;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader; build with +define+PROG_LOADER_CHECKSUM_EN
// to exercise the checksum byte and error path.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;
    localparam int NB      = INSTR_W / 8;
    localparam int EW      = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] BASE = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prog_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    prog_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [EW-1:0]      exp_q[$];
    logic [7:0]         stream_q[$];
    logic [INSTR_W-1:0] word_q[$];
    bit                 final_armed = 1'b0;
    bit                 chk_after   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_address"}, bus.prog_address, BASE);
        check({tag, "_wdata"}, bus.prog_wdata, 0);
        check({tag, "_we"}, bus.prog_write_enable, 0);
        check({tag, "_hold_done_error"}, {bus.cpu_hold, bus.done, bus.error}, 3'b100);
        check({tag, "_state"}, bus.state, IDLE);
    endtask

    // Monitor: every write strobe is matched against the head of exp_q.
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (!rst) begin
            if (chk_after) begin
                chk_after = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                check("check_state_after_last_write", {bus.in_ready, bus.done}, 2'b10);
`else
                check("done_after_last_write", {bus.done, bus.cpu_hold, bus.in_ready}, 3'b100);
`endif
            end
            if (bus.prog_write_enable) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             bus.prog_address, bus.prog_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr_data", {bus.prog_address, bus.prog_wdata}, e);
                    check("hold_during_write", {bus.done, bus.cpu_hold}, 2'b01);
                    if (exp_q.size() == 0 && final_armed) begin
                        chk_after   = 1'b1;
                        final_armed = 1'b0;
                    end
                end
            end
        end
    end

    // Reference model: slice the stream into words straight from the format rules.
    task automatic expect_from_stream();
        int n;
        logic [INSTR_W-1:0] data;
        logic [ADDR_W-1:0]  a;
        n = (stream_q[0] == 8'd0) ? (1 << ADDR_W) : int'(stream_q[0]);
        for (int w = 0; w < n; w++) begin
            data = '0;
            for (int k = 0; k < NB; k++) data = (data << 8) | INSTR_W'(stream_q[1 + w*NB + k]);
            a = ADDR_W'((int'(BASE) + w) % (1 << ADDR_W));
            exp_q.push_back({a, data});
        end
    endtask

    task automatic build_stream(input int n_field);
        logic [7:0] x;
        x = 8'd0;
        stream_q.delete();
        stream_q.push_back(8'(n_field));
        foreach (word_q[i]) begin
            for (int k = NB - 1; k >= 0; k--) begin
                stream_q.push_back(word_q[i][k*8 +: 8]);
                x ^= word_q[i][k*8 +: 8];
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        stream_q.push_back(x);
`endif
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int  guard;
        bit  taken;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.start    = with_start;
        guard = 0;
        forever begin
            @(negedge clk);
            taken = bus.in_ready;
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (taken) break;
            guard++;
            if (guard > 200) begin
                total_cnt++;
                $display("FAIL byte_accept_timeout: got no acceptance of %0h expected in_ready", b);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic run_load(input int mode, input bit mid_start, output longint cycles);
        int     mid_idx;
        int     guard;
        bit     exp_err;
        longint t0;
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        expect_from_stream();
        exp_err = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
        x = 8'd0;
        for (int i = 1; i < stream_q.size() - 1; i++) x ^= stream_q[i];
        exp_err = (x != stream_q[stream_q.size() - 1]);
`endif
        mid_idx = mid_start ? int'($urandom_range(1, stream_q.size() - 1)) : -1;
        final_armed = 1'b1;
        t0 = longint'($time);
        pulse_start();
        foreach (stream_q[i]) send_byte(stream_q[i], pick_gap(mode), (i == mid_idx));
        guard = 0;
        forever begin
            @(negedge clk);
            if (bus.done) break;
            guard++;
            if (guard > 100) begin
                total_cnt++;
                $display("FAIL done_timeout: got done=0 expected done=1");
                break;
            end
        end
        cycles = (longint'($time) - t0) / 10;
        check("done_level", bus.done, 1);
        check("error_level", bus.error, exp_err);
        check("cpu_hold_level", bus.cpu_hold, exp_err);
        check("in_ready_in_done", bus.in_ready, 0);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        longint b_cyc;
        longint t_cyc;
        longint cyc;
        int     nbytes;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #1;
        check_reset("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle with no start: junk bytes must not be consumed, no writes.
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'(($urandom_range(0, 1)));
            bus.in_data  = 8'($urandom());
            @(negedge clk);
            check("idle_levels", {bus.in_ready, bus.done, bus.cpu_hold}, 3'b001);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        word_q = '{32'h1000000C, 32'h1010000C};
        build_stream(2);
        nbytes = stream_q.size();
        run_load(0, 1'b0, b_cyc);
        run_load(1, 1'b0, t_cyc);
        check("toggle_slowdown", (t_cyc >= b_cyc + nbytes - 1), 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        word_q = '{32'hDEADBEEF};
        build_stream(1);
        stream_q[stream_q.size() - 1] = 8'h22;
        run_load(0, 1'b0, cyc);
        stream_q[stream_q.size() - 1] = 8'h23;
        run_load(0, 1'b0, cyc);
`endif

        // Count byte 0: full 256-word load with an incrementing byte pattern.
        word_q.delete();
        for (int w = 0; w < 256; w++) begin
            word_q.push_back({8'(4*w), 8'(4*w + 1), 8'(4*w + 2), 8'(4*w + 3)});
        end
        build_stream(0);
        run_load(0, 1'b0, cyc);
        check("wrap_address", bus.prog_address, BASE);

        // Reset after six data bytes, then a clean reload.
        word_q = '{32'hCAFE0001, 32'h12345678};
        build_stream(2);
        expect_from_stream();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        pulse_start();
        for (int i = 0; i < 7; i++) send_byte(stream_q[i], 0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_reset("rst_mid");
        check("rst_mid_queue", exp_q.size(), 0);
        final_armed = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_load(2, 1'b0, cyc);

        // Random loads, each with a stray start pulse during the stream.
        for (int it = 0; it < 8; it++) begin
            int n;
            n = int'($urandom_range(1, 5));
            word_q.delete();
            for (int w = 0; w < n; w++) word_q.push_back(INSTR_W'($urandom()));
            build_stream(n);
            run_load(int'($urandom_range(0, 2)), 1'b1, cyc);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for the io_bus program-memory port: accepts a byte stream (host/UART side), packs it into 32-bit instructions and writes them into program memory at consecutive addresses.
- Holds the cpu in reset for the whole load and releases it only after a successful load.
- Replaces bench-side direct assignment of program memory, so the same load path works in simulation and on hardware.

Parameters:
- INSTR_W, 32, instruction width in bits; must be a multiple of 8.
- ADDR_W, 8, program-memory address width (256 words).
- BASE_ADDR, 8'h00, first program address written; matches PROGRAM_START.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle pulse that begins a load; accepted only in IDLE or DONE.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte accepted on a cycle where in_valid && in_ready.
- prog_address  output  ADDR_W  program-memory write address.
- prog_wdata  output  INSTR_W  program-memory write data.
- prog_write_enable  output  1  one-cycle write strobe.
- cpu_hold  output  1  drives cpu rst; high while not loaded.
- done  output  1  load finished; level signal.
- error  output  1  load failed; level signal.

Behaviour:
- Reset values:
  - in_ready=0, prog_address=BASE_ADDR, prog_wdata=0, prog_write_enable=0.
  - cpu_hold=1, done=0, error=0.
  - State=IDLE.
- Stream format: byte 0 is word count N, where 0 means 2^ADDR_W words. It is followed by N*INSTR_W/8 bytes, most significant byte first per word.
- States and transitions:
  - IDLE: in_ready=0. start -> COUNT.
  - COUNT: in_ready=1. Accepted byte loads the word counter -> DATA. Byte counter cleared; address reset to BASE_ADDR.
  - DATA: in_ready=1. Each accepted byte shifts into the packer.
    - On the last byte of a word: next cycle prog_write_enable=1 for exactly one cycle, with prog_address=current address and prog_wdata=packed word. Address then increments, wrapping modulo 2^ADDR_W.
    - in_ready stays 1 during the write cycle, so a back-to-back stream sustains 1 byte/cycle.
    - After the last byte of word N -> CHECK if CHECKSUM_EN is defined, else DONE.
  - DONE: in_ready=0, done=1. cpu_hold=error, so a good load releases the cpu.
    - done and the cpu_hold release take effect the cycle after the final write strobe.
    - start in DONE -> COUNT: clears done and error, and reasserts cpu_hold in the same cycle the state changes.
- Boundary conditions:
  - start outside IDLE/DONE: ignored.
  - in_valid low: no progress; counters hold. There is no timeout.
  - N=0: load 256 words; the address wraps to BASE_ADDR after the final write.
  - Bytes presented while in_ready=0: not consumed; the loader has no side effects from them.
  - rst mid-load: immediate return to reset values. The partial program is left in memory; cpu_hold=1.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all data bytes (count byte excluded) is kept during the load.
  - CHECK state: in_ready=1; accepts one checksum byte, then -> DONE.
  - On mismatch: error=1 and cpu_hold stays 1 in DONE.
- Undefined:
  - No CHECK state; error is tied 0.
  - DATA goes directly to DONE.

Decomposition:
- Shared header package:
  - loader_state_t enum {IDLE, COUNT, DATA, CHECK, DONE}.
  - PROG_DEPTH and INSTR_BYTES constants.
  - STALL_INSTRUCTION, reused by benches to pre-fill memory.
- One sub-module, byte_packer:
  - INSTR_W/8-deep MSB-first shift register with byte counter.
  - Asserts word_valid for one cycle with the packed word.
  - Has clear and enable inputs.

Test Plan:
- Reset release, no start -> cpu_hold=1, in_ready=0, done=0; no write strobes for 20 cycles.
- start; stream 02, 10 00 00 0C, 10 10 00 0C back-to-back -> strobes at addr 00 data 1000000C and addr 01 data 1010000C, one cycle each; done=1 and cpu_hold=0 the cycle after the last strobe.
- Same load with in_valid toggled every other cycle -> identical writes and data; total cycles roughly doubled.
- Count byte 00 with 1024 bytes of incrementing pattern -> 256 strobes at addr 00..FF; address wraps to 00 afterwards.
- rst pulsed after 6 data bytes -> all outputs return to reset values immediately; a following start and full stream loads correctly.
- PROG_LOADER_CHECKSUM_EN: stream 01, DE AD BE EF, then 22 -> done=1, error=0, cpu_hold=0. Same stream with checksum 23 -> error=1, cpu_hold=1.
